// File: rtl/seqdet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seqdet_ctrl
// Purpose  : Programmable serial pattern-detection controller. Holds a pattern
//            of 1..PAT_MAX bits. Runs detection over a qualified serial bit
//            stream and counts overlapping matches. A run ends on a match
//            target, on a bit budget, or on an abort.
// Ports    : clk, reset (sync, active-low)
//            cfg_valid/cfg_ready handshake with cfg_pattern, cfg_len,
//              cfg_target, cfg_budget
//            start, abort                 run control
//            din, din_valid               qualified serial input
//            match, match_cnt, bit_cnt    detection results
//            done, timeout, cfg_err       completion / error status
//            busy, state                  FSM visibility
// Revision : 1.0 - initial release
// ============================================================================
module seqdet_ctrl #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  parameter int BUD_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [BUD_W-1:0]   cfg_budget,
  input  logic               start,
  input  logic               abort,
  input  logic               din,
  input  logic               din_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [BUD_W-1:0]   bit_cnt,
  output logic               done,
  output logic               timeout,
  output logic               cfg_err,
  output logic               busy,
  output logic [2:0]         state
);

  localparam logic [3:0] c_pat_max = 4'(PAT_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_ARMED = 3'b001,
    S_RUN   = 3'b010,
    S_DONE  = 3'b011
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Configuration registers
  logic [PAT_MAX-1:0] r_pattern;
  logic [3:0]         r_len;
  logic [CNT_W-1:0]   r_target;
  logic [BUD_W-1:0]   r_budget;

  // Run registers
  logic [PAT_MAX-1:0] r_hist;
  logic [3:0]         r_fill;
  logic [CNT_W-1:0]   r_mcnt;
  logic [BUD_W-1:0]   r_bcnt;
  logic               r_match;
  logic               r_timeout;
  logic               r_cfg_err;

  // Combinational control / datapath
  logic               w_cfg_hs;
  logic               w_len_ok;
  logic               w_load_cfg;
  logic               w_cfg_bad;
  logic               w_start_run;
  logic               w_step;
  logic [PAT_MAX-1:0] w_mask;
  logic [PAT_MAX-1:0] w_hist_next;
  logic [3:0]         w_fill_next;
  logic               w_hit;
  logic [CNT_W-1:0]   w_mcnt_next;
  logic [BUD_W-1:0]   w_bcnt_next;
  logic               w_end_success;
  logic               w_end_timeout;

  // --------------------------------------------------------------------------
  // Compare mask: the low r_len bits of history and pattern take part.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
    assign w_mask[gi] = (4'(gi) < r_len);
  end

  // --------------------------------------------------------------------------
  // Handshake and run strobes
  // --------------------------------------------------------------------------
  assign w_cfg_hs    = cfg_valid && cfg_ready;
  assign w_len_ok    = (cfg_len != 4'd0) && (cfg_len <= c_pat_max);
  assign w_load_cfg  = w_cfg_hs && w_len_ok;
  assign w_cfg_bad   = w_cfg_hs && !w_len_ok;
  // Any config handshake in ARMED takes precedence over start.
  assign w_start_run = (r_state == S_ARMED) && start && !cfg_valid;
  // An abort discards the bit offered on the same edge.
  assign w_step      = (r_state == S_RUN) && !abort && din_valid;

  // --------------------------------------------------------------------------
  // Next-value datapath for a sampled bit
  // --------------------------------------------------------------------------
  assign w_hist_next = {r_hist[PAT_MAX-2:0], din};
  assign w_fill_next = (r_fill == c_pat_max) ? r_fill : (r_fill + 4'd1);
  assign w_hit       = (w_fill_next >= r_len) &&
                       ((w_hist_next & w_mask) == (r_pattern & w_mask));
  assign w_mcnt_next = (w_hit && (r_mcnt != '1)) ? (r_mcnt + 1'b1) : r_mcnt;
  assign w_bcnt_next = (r_bcnt != '1) ? (r_bcnt + 1'b1) : r_bcnt;

  // Reaching the target beats reaching the budget on the same bit.
  assign w_end_success = (r_target != '0) && (w_mcnt_next == r_target);
  assign w_end_timeout = !w_end_success && (r_budget != '0) &&
                         (w_bcnt_next == r_budget);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    cfg_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (w_load_cfg) begin
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        cfg_ready = 1'b1;
        if (w_start_run) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          w_state_next = S_ARMED;
        end else if (w_step && (w_end_success || w_end_timeout)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_ARMED;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration and run datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_target  <= '0;
      r_budget  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_mcnt    <= '0;
      r_bcnt    <= '0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_step && w_hit;
      r_cfg_err <= w_cfg_bad;

      if (w_load_cfg) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_target  <= cfg_target;
        r_budget  <= cfg_budget;
      end

      if (w_start_run) begin
        r_hist    <= '0;
        r_fill    <= '0;
        r_mcnt    <= '0;
        r_bcnt    <= '0;
        r_timeout <= 1'b0;
      end

      if (w_step) begin
        r_hist <= w_hist_next;
        r_fill <= w_fill_next;
        r_mcnt <= w_mcnt_next;
        r_bcnt <= w_bcnt_next;
        if (w_end_timeout) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign state     = r_state;
  assign match     = r_match;
  assign match_cnt = r_mcnt;
  assign bit_cnt   = r_bcnt;
  assign timeout   = r_timeout;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seqdet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seqdet_ctrl
// Purpose  : Directed self-checking bench for seqdet_ctrl with default
//            parameters (PAT_MAX=8, CNT_W=8, BUD_W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seqdet_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_budget;
  logic        start;
  logic        abort;
  logic        din;
  logic        din_valid;
  logic        match;
  logic [7:0]  match_cnt;
  logic [15:0] bit_cnt;
  logic        done;
  logic        timeout;
  logic        cfg_err;
  logic        busy;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  seqdet_ctrl #(
    .PAT_MAX(8),
    .CNT_W  (8),
    .BUD_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_target (cfg_target),
    .cfg_budget (cfg_budget),
    .start      (start),
    .abort      (abort),
    .din        (din),
    .din_valid  (din_valid),
    .match      (match),
    .match_cnt  (match_cnt),
    .bit_cnt    (bit_cnt),
    .done       (done),
    .timeout    (timeout),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic [7:0] tgt, input logic [15:0] bud);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_target  = tgt;
    cfg_budget  = bud;
    cycle();
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input logic b);
    din       = b;
    din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
  endtask

  task automatic gap();
    din = 1'b1;
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_target  = '0;
    cfg_budget  = '0;
    start       = 1'b0;
    abort       = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;

    // ---------------- reset state ----------------
    chk("rst_state",     32'(state),     32'h0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_done",      32'(done),      32'h0);
    chk("rst_match",     32'(match),     32'h0);
    chk("rst_mcnt",      32'(match_cnt), 32'h0);
    chk("rst_bcnt",      32'(bit_cnt),   32'h0);
    chk("rst_timeout",   32'(timeout),   32'h0);
    chk("rst_cfg_err",   32'(cfg_err),   32'h0);

    // start in IDLE is ignored
    do_start();
    chk("idle_start_ignored", 32'(state), 32'h0);

    // ---------------- overlapping match ----------------
    do_cfg(8'h0B, 4'd4, 8'd0, 16'd0);
    chk("ov_armed", 32'(state), 32'h1);
    do_start();
    chk("ov_run",       32'(state),     32'h2);
    chk("ov_busy",      32'(busy),      32'h1);
    chk("ov_cfg_ready", 32'(cfg_ready), 32'h0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    chk("ov_nomatch_b3", 32'(match), 32'h0);
    send(1'b1);
    chk("ov_match_b4", 32'(match),     32'h1);
    chk("ov_cnt_b4",   32'(match_cnt), 32'h1);
    send(1'b0);
    chk("ov_nomatch_b5", 32'(match), 32'h0);
    send(1'b1);
    chk("ov_nomatch_b6", 32'(match), 32'h0);
    send(1'b1);
    chk("ov_match_b7", 32'(match),     32'h1);
    chk("ov_cnt_b7",   32'(match_cnt), 32'h2);
    chk("ov_bcnt",     32'(bit_cnt),   32'h7);
    chk("ov_state",    32'(state),     32'h2);

    // ---------------- reset mid-run ----------------
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("mr_state",     32'(state),     32'h0);
    chk("mr_cfg_ready", 32'(cfg_ready), 32'h1);
    chk("mr_done",      32'(done),      32'h0);
    chk("mr_mcnt",      32'(match_cnt), 32'h0);
    chk("mr_bcnt",      32'(bit_cnt),   32'h0);
    chk("mr_busy",      32'(busy),      32'h0);
    do_start();
    chk("mr_start_ignored", 32'(state), 32'h0);

    // ---------------- target stop with gaps ----------------
    do_cfg(8'h0B, 4'd4, 8'd2, 16'd0);
    do_start();
    send(1'b1); gap();
    send(1'b0); gap(); gap();
    chk("ts_gap_hold", 32'(bit_cnt), 32'h2);
    send(1'b1);
    send(1'b1); gap();
    send(1'b0);
    send(1'b1); gap();
    send(1'b1);
    chk("ts_done",    32'(done),    32'h1);
    chk("ts_state3",  32'(state),   32'h3);
    chk("ts_busy",    32'(busy),    32'h0);
    chk("ts_timeout", 32'(timeout), 32'h0);
    cycle();
    chk("ts_done_off", 32'(done),      32'h0);
    chk("ts_armed",    32'(state),     32'h1);
    chk("ts_mcnt",     32'(match_cnt), 32'h2);
    chk("ts_bcnt",     32'(bit_cnt),   32'h7);

    // ---------------- budget timeout ----------------
    do_cfg(8'h0B, 4'd4, 8'd1, 16'd5);
    do_start();
    send(1'b0); send(1'b0); send(1'b0); send(1'b0);
    chk("bt_still_run", 32'(state), 32'h2);
    send(1'b0);
    chk("bt_done",    32'(done),    32'h1);
    chk("bt_timeout", 32'(timeout), 32'h1);
    cycle();
    chk("bt_armed",        32'(state),     32'h1);
    chk("bt_mcnt",         32'(match_cnt), 32'h0);
    chk("bt_timeout_hold", 32'(timeout),   32'h1);

    // ---------------- success wins tie ----------------
    do_cfg(8'h0B, 4'd4, 8'd1, 16'd4);
    do_start();
    chk("tie_timeout_clr", 32'(timeout), 32'h0);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    chk("tie_done",    32'(done),      32'h1);
    chk("tie_timeout", 32'(timeout),   32'h0);
    chk("tie_mcnt",    32'(match_cnt), 32'h1);
    cycle();

    // config and start together: config wins
    cfg_valid   = 1'b1;
    cfg_pattern = 8'h0B;
    cfg_len     = 4'd4;
    cfg_target  = 8'd1;
    cfg_budget  = 16'd4;
    start       = 1'b1;
    cycle();
    cfg_valid   = 1'b0;
    start       = 1'b0;
    chk("cfg_beats_start", 32'(state), 32'h1);

    // ---------------- abort ----------------
    do_start();
    send(1'b0); send(1'b0); send(1'b0);
    abort     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b1;
    cycle();
    abort     = 1'b0;
    din_valid = 1'b0;
    chk("ab_state", 32'(state),   32'h1);
    chk("ab_done",  32'(done),    32'h0);
    chk("ab_bcnt",  32'(bit_cnt), 32'h3);
    cycle();
    chk("ab_done_later", 32'(done), 32'h0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("ab_outside_run", 32'(state), 32'h1);

    // ---------------- illegal config ----------------
    do_cfg(8'hFF, 4'd0, 8'd0, 16'd0);
    chk("ic0_err",   32'(cfg_err), 32'h1);
    chk("ic0_state", 32'(state),   32'h1);
    cycle();
    chk("ic0_err_pulse", 32'(cfg_err), 32'h0);
    do_cfg(8'hFF, 4'd9, 8'd0, 16'd0);
    chk("ic9_err", 32'(cfg_err), 32'h1);
    do_start();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    chk("ic_old_pat_match", 32'(match), 32'h1);
    chk("ic_old_tgt_done",  32'(state), 32'h3);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seqdet_ctrl.md
Name: seqdet_ctrl

Overview:
- Programmable serial pattern-detection controller: holds a configurable pattern of 1..PAT_MAX bits and sequences a detection run over a qualified bit stream.
- Counts overlapping matches and ends the run on a match target, a bit budget or an abort.
- Sits between the configuration/host side and the serial input of the sequence-detector datapath.
- Exposes state, counters and completion status.

Parameters:
PAT_MAX, 8, maximum pattern length in bits (2..15)
CNT_W, 8, width of match counter and match target
BUD_W, 16, width of bit counter and bit budget

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset
cfg_valid  input  1  configuration offer
cfg_ready  output  1  configuration accepted when cfg_valid and cfg_ready are both high at a rising edge
cfg_pattern  input  PAT_MAX  pattern; bit 0 is the newest (last-received) bit
cfg_len  input  4  pattern length, legal 1..PAT_MAX
cfg_target  input  CNT_W  matches that end a run; 0 = no target
cfg_budget  input  BUD_W  bits that end a run; 0 = unlimited
start  input  1  begin run
abort  input  1  stop run
din  input  1  serial data bit
din_valid  input  1  din qualifier
match  output  1  one-cycle match pulse
match_cnt  output  CNT_W  matches this run, saturating
bit_cnt  output  BUD_W  valid bits this run, saturating
done  output  1  one-cycle run-complete pulse
timeout  output  1  last run ended on budget
cfg_err  output  1  one-cycle illegal-config pulse
busy  output  1  high in RUN
state  output  3  FSM state

Behaviour:
- Reset is synchronous, sampled at the rising clk edge while reset is 0. It wins over every other input.
- Reset values:
  - state = IDLE.
  - Pattern, length, target and budget registers cleared.
  - History cleared.
  - All outputs 0, except cfg_ready = 1.
- Reset mid-run discards the run with no done pulse.
- States:
  - IDLE = 000
  - ARMED = 001
  - RUN = 010
  - DONE = 011
  - Codes 1xx go to IDLE on the next edge.
- cfg_ready = 1 in IDLE and ARMED, 0 in RUN and DONE.
- Config handshake, legal cfg_len:
  - Load all four cfg fields.
  - Move to ARMED.
- Config handshake, cfg_len = 0 or > PAT_MAX:
  - Handshake completes.
  - Registers and state are unchanged.
  - cfg_err = 1 for the following cycle.
- start is honoured in ARMED only; it is ignored in IDLE, RUN and DONE.
- start in ARMED:
  - Go to RUN.
  - Clear match_cnt, bit_cnt, history and history-fill count.
  - Clear timeout.
- If cfg_valid and start arrive together in ARMED, the config wins and start is ignored.
- RUN, each edge with din_valid = 1:
  - history <= {history[PAT_MAX-2:0], din}.
  - Fill count increments, saturating at PAT_MAX.
  - bit_cnt increments, saturating.
- RUN, match evaluation: a hit is fill >= len and the low len bits of the next history equal the low len bits of the pattern.
  - match = hit, registered: high in the cycle after the sampled bit.
  - Matches overlap; history is not flushed after a hit.
  - match_cnt increments on a hit and saturates at all-ones.
- RUN, edges with din_valid = 0: no change.
- Run end, evaluated on the same edge as the bit update:
  - Success when target != 0 and the next match_cnt = target: go to DONE with timeout = 0.
  - Timeout otherwise, when budget != 0 and the next bit_cnt = budget: go to DONE with timeout = 1.
  - Target and budget reached on the same bit: success, timeout = 0.
- abort in RUN:
  - Go to ARMED on the next edge with no done pulse.
  - Counters are frozen and readable.
  - Any din on that edge is ignored.
- abort outside RUN is ignored.
- DONE lasts exactly one cycle:
  - done = 1 and busy = 0.
  - Then go to ARMED with config retained.
  - match_cnt, bit_cnt and timeout hold until the next start.
- busy = 1 exactly when state = RUN.

Test Plan:
- Reset mid-run: reset = 0 for 1 cycle while in RUN -> state = 000, all outputs 0, cfg_ready = 1, and no done pulse. A following start is ignored until a new config is loaded.
- Overlapping match: cfg pattern = 0x0B, len = 4, target = 0, budget = 0; start; din = 1,0,1,1,0,1,1 on consecutive valid cycles -> match pulses after bits 4 and 7, match_cnt = 2, state remains 010.
- Target stop: same config with target = 2; stream 1011011 with gaps in din_valid -> done pulse one cycle after bit 7, timeout = 0, then state = 001, match_cnt = 2, bit_cnt = 7.
- Budget timeout: pattern 0x0B, len = 4, target = 1, budget = 5; stream 0,0,0,0,0 -> done after bit 5, timeout = 1, match_cnt = 0.
- Success wins on a tie: target = 1, budget = 4; stream 1011 -> done after bit 4 with timeout = 0.
- Abort and illegal config:
  - Abort during RUN after 3 bits -> state = 001, no done pulse, bit_cnt = 3.
  - cfg_len = 0 -> cfg_err pulse, state unchanged.
  - cfg_len = 9 -> cfg_err pulse, previous pattern still matches.
